// File: rtl/conv_pkg.sv
// Shared types and elaboration-time helpers for the streaming 2D convolution engine.
package conv_pkg;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        MAC  = 2'd1,
        EMIT = 2'd2
    } state_t;

    // Width of an index over n entries, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int acc_width(input int pix_w, input int coef_w, input int taps);
        return pix_w + coef_w + $clog2(taps);
    endfunction

    function automatic int out_count(input int img_w, input int img_h, input int k);
        return (img_h - k + 1) * (img_w - k + 1);
    endfunction

endpackage

// File: rtl/conv_mac.sv
// Registered multiply-accumulate: pixel (always unsigned) times coefficient,
// unsigned or two's complement, summed into an ACC_W-bit register.
module conv_mac #(
    parameter int PIX_W       = 8,
    parameter int COEF_W      = 8,
    parameter int ACC_W       = 20,
    parameter int SIGNED_COEF = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clr,
    input  logic              i_en,
    input  logic [PIX_W-1:0]  i_pix,
    input  logic [COEF_W-1:0] i_coef,
    output logic [ACC_W-1:0]  o_acc
);

    localparam int PW = PIX_W + COEF_W;

    logic [ACC_W-1:0] w_prod;
    logic [ACC_W-1:0] r_acc;

    generate
        if (SIGNED_COEF != 0) begin : g_signed
            // The pixel gains a zero sign bit so it stays positive in the signed product.
            logic signed [PIX_W:0]    w_pix_s;
            logic signed [COEF_W-1:0] w_coef_s;
            logic signed [PW:0]       w_prod_s;
            assign w_pix_s  = {1'b0, i_pix};
            assign w_coef_s = i_coef;
            assign w_prod_s = (PW + 1)'(w_pix_s) * (PW + 1)'(w_coef_s);
            assign w_prod   = ACC_W'(w_prod_s);
        end else begin : g_unsigned
            logic [PW-1:0] w_prod_u;
            assign w_prod_u = PW'(i_pix) * PW'(i_coef);
            assign w_prod   = ACC_W'(w_prod_u);
        end
    endgenerate

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of the order blocks are evaluated in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= r_acc + w_prod;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/conv2d_stream_engine.sv
// Buffers one raster-order frame, then walks every valid-mode KxK window with a
// single MAC, presenting each result on a valid/ready stream.
module conv2d_stream_engine
    import conv_pkg::*;
#(
    parameter int IMG_W       = 5,
    parameter int IMG_H       = 5,
    parameter int K           = 3,
    parameter int PIX_W       = 8,
    parameter int COEF_W      = 8,
    parameter int SIGNED_COEF = 0,
    localparam int ACC_W      = acc_width(PIX_W, COEF_W, K * K),
    localparam int CA_W       = cnt_width(K * K)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              coef_we,
    input  logic [CA_W-1:0]   coef_addr,
    input  logic [COEF_W-1:0] coef_wdata,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic [PIX_W-1:0]  pix_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic              out_last,
    output logic              busy
);

    localparam int KK        = K * K;
    localparam int NPIX      = IMG_W * IMG_H;
    localparam int PIX_IDX_W = cnt_width(NPIX);
    localparam int TAP_W     = cnt_width(KK + 1);
    localparam int OY_W      = cnt_width(IMG_H);
    localparam int OX_W      = cnt_width(IMG_W);
    localparam int M_W       = cnt_width(K + 1);
    localparam int N_W       = cnt_width(K);

    state_t                 r_state;
    logic [PIX_IDX_W-1:0]   r_pix_cnt;
    logic [OY_W-1:0]        r_oy;
    logic [OX_W-1:0]        r_ox;
    logic [M_W-1:0]         r_m;
    logic [N_W-1:0]         r_n;
    logic [TAP_W-1:0]       r_tap;
    logic                   r_pix_ready;
    logic                   r_busy;
    logic                   r_out_valid;
    logic                   r_out_last;
    logic [ACC_W-1:0]       r_out_data;
    logic [COEF_W-1:0]      r_coef [KK];
    logic [PIX_W-1:0]       r_buf  [NPIX];

    logic [PIX_IDX_W-1:0]   w_buf_idx;
    logic                   w_mac_clr;
    logic                   w_mac_en;
    logic                   w_pix_xfer;
    logic [ACC_W-1:0]       w_acc;

    assign w_pix_xfer = pix_valid && r_pix_ready;
    assign w_buf_idx  = PIX_IDX_W'((32'(r_oy) + 32'(r_m)) * 32'(IMG_W) + 32'(r_ox) + 32'(r_n));
    // The accumulator sits at zero outside MAC, so every window starts clean.
    assign w_mac_clr  = (r_state != MAC);
    assign w_mac_en   = (r_state == MAC) && (r_tap != TAP_W'(KK));

    conv_mac #(
        .PIX_W       (PIX_W),
        .COEF_W      (COEF_W),
        .ACC_W       (ACC_W),
        .SIGNED_COEF (SIGNED_COEF)
    ) u_mac (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_mac_clr),
        .i_en   (w_mac_en),
        .i_pix  (r_buf[w_buf_idx]),
        .i_coef (r_coef[r_tap[CA_W-1:0]]),
        .o_acc  (w_acc)
    );

    // NOTE: the frame buffer has no reset; every entry is rewritten by the
    // incoming frame before the MAC phase can read it.
    always_ff @(posedge clk) begin
        if (w_pix_xfer) begin
            r_buf[r_pix_cnt] <= pix_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < KK; i++) begin
                r_coef[i] <= '0;
            end
        end else if (r_state == LOAD && coef_we && ({1'b0, coef_addr} < (CA_W + 1)'(KK))) begin
            r_coef[coef_addr] <= coef_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= LOAD;
            r_pix_cnt   <= '0;
            r_oy        <= '0;
            r_ox        <= '0;
            r_m         <= '0;
            r_n         <= '0;
            r_tap       <= '0;
            r_pix_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
        end else begin
            case (r_state)
                LOAD: begin
                    if (w_pix_xfer) begin
                        if (r_pix_cnt == PIX_IDX_W'(NPIX - 1)) begin
                            r_pix_cnt   <= '0;
                            r_oy        <= '0;
                            r_ox        <= '0;
                            r_m         <= '0;
                            r_n         <= '0;
                            r_tap       <= '0;
                            r_pix_ready <= 1'b0;
                            r_busy      <= 1'b1;
                            r_state     <= MAC;
                        end else begin
                            r_pix_cnt <= r_pix_cnt + 1'b1;
                        end
                    end
                end
                MAC: begin
                    // One extra cycle at tap==K*K lets the last product land in the accumulator.
                    if (r_tap == TAP_W'(KK)) begin
                        r_out_data  <= w_acc;
                        r_out_valid <= 1'b1;
                        r_out_last  <= (r_oy == OY_W'(IMG_H - K)) && (r_ox == OX_W'(IMG_W - K));
                        r_state     <= EMIT;
                    end else begin
                        r_tap <= r_tap + 1'b1;
                        if (r_n == N_W'(K - 1)) begin
                            r_n <= '0;
                            r_m <= r_m + 1'b1;
                        end else begin
                            r_n <= r_n + 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        if (r_out_last) begin
                            r_pix_ready <= 1'b1;
                            r_busy      <= 1'b0;
                            r_state     <= LOAD;
                        end else begin
                            if (r_ox == OX_W'(IMG_W - K)) begin
                                r_ox <= '0;
                                r_oy <= r_oy + 1'b1;
                            end else begin
                                r_ox <= r_ox + 1'b1;
                            end
                            r_tap   <= '0;
                            r_m     <= '0;
                            r_n     <= '0;
                            r_state <= MAC;
                        end
                    end
                end
                default: r_state <= LOAD;
            endcase
        end
    end

    assign pix_ready = r_pix_ready;
    assign busy      = r_busy;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign out_data  = r_out_data;

endmodule

// File: tb/tb_conv2d_stream_engine.sv
// Randomised bench for conv2d_stream_engine: an unsigned and a signed instance share
// all inputs and are checked against a direct window-sum model of the frame.
module tb_conv2d_stream_engine;

    localparam int IW   = 5;
    localparam int IH   = 5;
    localparam int KS   = 3;
    localparam int NPIX = IW * IH;
    localparam int NTAP = KS * KS;
    localparam int OW   = IW - KS + 1;
    localparam int NOUT = (IH - KS + 1) * OW;
    localparam int LAT  = NTAP + 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        coef_we;
    logic [3:0]  coef_addr;
    logic [7:0]  coef_wdata;
    logic        pix_valid;
    logic [7:0]  pix_data;
    logic        out_ready;

    logic        pix_ready_u, out_valid_u, out_last_u, busy_u;
    logic [19:0] out_data_u;
    logic        pix_ready_s, out_valid_s, out_last_s, busy_s;
    logic [19:0] out_data_s;

    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          last_edge = 0;
    logic [7:0]  img   [NPIX];
    logic [7:0]  mcoef [NTAP];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    conv2d_stream_engine #(.SIGNED_COEF(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_wdata(coef_wdata), .pix_valid(pix_valid), .pix_ready(pix_ready_u),
        .pix_data(pix_data), .out_valid(out_valid_u), .out_ready(out_ready),
        .out_data(out_data_u), .out_last(out_last_u), .busy(busy_u)
    );

    conv2d_stream_engine #(.SIGNED_COEF(1)) u_dut_s (
        .clk(clk), .rst_n(rst_n), .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_wdata(coef_wdata), .pix_valid(pix_valid), .pix_ready(pix_ready_s),
        .pix_data(pix_data), .out_valid(out_valid_s), .out_ready(out_ready),
        .out_data(out_data_s), .out_last(out_last_s), .busy(busy_s)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Window sum straight from the definition of a valid-mode convolution.
    function automatic logic [19:0] model(input bit sgn, input int oy, input int ox);
        int s;
        int c;
        s = 0;
        for (int m = 0; m < KS; m++) begin
            for (int n = 0; n < KS; n++) begin
                c = sgn ? int'($signed(mcoef[m * KS + n])) : int'(mcoef[m * KS + n]);
                s += int'(img[(oy + m) * IW + ox + n]) * c;
            end
        end
        return 20'(s);
    endfunction

    task automatic write_coef(input int a, input logic [7:0] d);
        @(negedge clk);
        coef_we    = 1'b1;
        coef_addr  = 4'(a);
        coef_wdata = d;
        if (a < NTAP) mcoef[a] = d;
        @(negedge clk);
        coef_we = 1'b0;
    endtask

    task automatic set_all_coef(input logic [7:0] d);
        for (int i = 0; i < NTAP; i++) write_coef(i, d);
    endtask

    task automatic send_frame(input bit gaps, input bit cw);
        int i;
        int wi;
        int guard;
        i = 0;
        wi = 0;
        guard = 0;
        while (i < NPIX) begin
            @(negedge clk);
            guard++;
            if (guard > 500) begin
                check("load_timeout", 32'd0, 32'd1);
                break;
            end
            coef_we = 1'b0;
            if (cw && wi < 12) begin
                coef_we    = 1'b1;
                coef_addr  = 4'(wi);
                coef_wdata = 8'($urandom);
                if (wi < NTAP) mcoef[wi] = coef_wdata;
                wi++;
            end
            if (gaps && $urandom_range(0, 2) == 0) begin
                pix_valid = 1'b0;
            end else begin
                pix_valid = 1'b1;
                pix_data  = img[i];
            end
            if (pix_valid && pix_ready_u) begin
                i++;
                if (i == NPIX) last_edge = cyc + 1;
            end
        end
        @(negedge clk);
        pix_valid = 1'b0;
        coef_we   = 1'b0;
    endtask

    task automatic collect(input int first_stall, input bit rand_stall, input bit mac_we);
        int          ref_edge;
        int          t;
        int          stall;
        logic [19:0] eu;
        logic [19:0] es;
        ref_edge = last_edge;
        for (int r = 0; r < NOUT; r++) begin
            eu = model(1'b0, r / OW, r % OW);
            es = model(1'b1, r / OW, r % OW);
            t = 0;
            while (!out_valid_u && t < 200) begin
                if (mac_we) begin
                    coef_we    = 1'b1;
                    coef_addr  = 4'($urandom_range(0, NTAP - 1));
                    coef_wdata = 8'($urandom);
                end
                @(negedge clk);
                t++;
            end
            coef_we = 1'b0;
            if (!out_valid_u) begin
                check("valid_timeout", 32'd0, 32'd1);
                return;
            end
            check($sformatf("latency[%0d]", r), 32'(cyc - ref_edge), 32'(LAT));
            stall = (r == 0) ? first_stall : (rand_stall ? int'($urandom_range(0, 3)) : 0);
            for (int s = 0; s < stall; s++) begin
                check($sformatf("hold_data[%0d]", r), 32'(out_data_u), 32'(eu));
                check($sformatf("hold_valid[%0d]", r), 32'(out_valid_u), 32'd1);
                @(negedge clk);
            end
            check($sformatf("data_u[%0d]", r), 32'(out_data_u), 32'(eu));
            check($sformatf("data_s[%0d]", r), 32'(out_data_s), 32'(es));
            check($sformatf("valid_s[%0d]", r), 32'(out_valid_s), 32'd1);
            check($sformatf("last[%0d]", r), 32'(out_last_u), 32'(r == NOUT - 1));
            check($sformatf("pix_ready_busy[%0d]", r), 32'(pix_ready_u), 32'd0);
            check($sformatf("busy[%0d]", r), 32'(busy_u), 32'd1);
            out_ready = 1'b1;
            ref_edge  = cyc + 1;
            @(negedge clk);
            out_ready = 1'b0;
            check($sformatf("valid_drop[%0d]", r), 32'(out_valid_u), 32'd0);
        end
        check("ready_after_frame", 32'(pix_ready_u), 32'd1);
        check("busy_after_frame", 32'(busy_u), 32'd0);
    endtask

    task automatic ramp_image();
        for (int i = 0; i < NPIX; i++) img[i] = 8'(i);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        coef_we    = 1'b0;
        coef_addr  = '0;
        coef_wdata = '0;
        pix_valid  = 1'b0;
        pix_data   = '0;
        out_ready  = 1'b0;
        for (int i = 0; i < NTAP; i++) mcoef[i] = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_pix_ready", 32'(pix_ready_u), 32'd1);
        check("rst_busy", 32'(busy_u), 32'd0);
        check("rst_out_valid", 32'(out_valid_u), 32'd0);
        check("rst_out_data", 32'(out_data_u), 32'd0);
        check("rst_out_last", 32'(out_last_u), 32'd0);
        check("rst_out_valid_s", 32'(out_valid_s), 32'd0);

        // All-ones kernel over a ramp.
        set_all_coef(8'd1);
        ramp_image();
        send_frame(1'b0, 1'b0);
        collect(0, 1'b0, 1'b0);

        // Centre tap only; out-of-range addresses must not disturb the bank.
        set_all_coef(8'd0);
        write_coef(4, 8'd1);
        write_coef(9, 8'h77);
        write_coef(15, 8'h33);
        send_frame(1'b0, 1'b0);
        collect(0, 1'b0, 1'b0);

        // Extreme values: 0xFF is -1 to the signed instance and 255 to the unsigned one.
        set_all_coef(8'hFF);
        for (int i = 0; i < NPIX; i++) img[i] = 8'hFF;
        send_frame(1'b0, 1'b0);
        collect(0, 1'b0, 1'b0);

        // Backpressure on the first result and gappy input.
        set_all_coef(8'd1);
        ramp_image();
        send_frame(1'b1, 1'b0);
        collect(5, 1'b0, 1'b0);

        // Random frames with coefficient writes overlapping pixel transfers.
        for (int it = 0; it < 3; it++) begin
            for (int i = 0; i < NPIX; i++) img[i] = 8'($urandom);
            send_frame(1'b1, 1'b1);
            collect(0, 1'b1, 1'b0);
        end

        // Coefficient writes while computing are ignored.
        set_all_coef(8'd1);
        ramp_image();
        send_frame(1'b0, 1'b0);
        collect(0, 1'b1, 1'b1);

        // Reset in the middle of a window drops the frame and clears the bank.
        send_frame(1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid_u), 32'd0);
        check("midrst_busy", 32'(busy_u), 32'd0);
        check("midrst_pix_ready", 32'(pix_ready_u), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NTAP; i++) mcoef[i] = '0;
        @(negedge clk);
        check("postrst_out_valid", 32'(out_valid_u), 32'd0);
        for (int i = 0; i < NPIX; i++) img[i] = 8'($urandom);
        send_frame(1'b1, 1'b0);
        collect(0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
